// File: rtl/assoc_popcount_argmax_if.sv
// Handshake and result bundle between the query-AND array, the popcount/argmax block
// and the classifier result register.
interface assoc_popcount_argmax_if #(
  parameter int BITWIDTH    = 5,
  parameter int NUM_CLASSES = 26,
  parameter int NUM_CHUNKS  = 4
);
  localparam int CNT_W = $clog2(BITWIDTH*NUM_CHUNKS+1);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic                            start;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_CLASSES*BITWIDTH-1:0] and_vec;
  logic                            busy;
  logic                            done;
  logic [IDX_W-1:0]                class_idx;
  logic [CNT_W-1:0]                best_score;

  modport master (
    output start, in_valid, and_vec,
    input  in_ready, busy, done, class_idx, best_score
  );

  modport slave (
    input  start, in_valid, and_vec,
    output in_ready, busy, done, class_idx, best_score
  );
endinterface

// File: rtl/assoc_popcount_argmax.sv
// Accumulates per-class popcounts of ANDed query chunks, then scans the class scores one
// per cycle and reports the lowest-index class with the highest score.
module assoc_popcount_argmax #(
  parameter int BITWIDTH    = 5,
  parameter int NUM_CLASSES = 26,
  parameter int NUM_CHUNKS  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  assoc_popcount_argmax_if.slave bus
);
  localparam int CNT_W = $clog2(BITWIDTH*NUM_CHUNKS+1);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int CHK_W = $clog2(NUM_CHUNKS+1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [BITWIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < BITWIDTH; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_t           state_r, state_n;
  logic [CNT_W-1:0] score_r [NUM_CLASSES];
  logic [CNT_W-1:0] pc_s    [NUM_CLASSES];
  logic [CHK_W-1:0] chunk_cnt_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] best_r;
  logic [IDX_W-1:0] class_idx_r;
  logic [CNT_W-1:0] best_score_r;
  logic             done_r;
  logic             busy_r;
  logic             in_ready_r;

  logic             take_s;
  logic             last_chunk_s;
  logic             clear_s;
  logic             arg_first_s;
  logic             arg_last_s;
  logic [CNT_W-1:0] cand_s;
  logic             better_s;
  logic [CNT_W-1:0] best_n_s;
  logic [IDX_W-1:0] idx_n_s;

  assign take_s       = (state_r == ST_ACCUM) && bus.in_valid;
  assign last_chunk_s = take_s && (chunk_cnt_r == CHK_W'(NUM_CHUNKS-1));
  assign clear_s      = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  // ptr is cleared on every query start, so ptr==0 inside ARGMAX marks the load cycle
  assign arg_first_s  = (state_r == ST_ARGMAX) && (ptr_r == {IDX_W{1'b0}});
  assign arg_last_s   = (state_r == ST_ARGMAX) && (ptr_r == IDX_W'(NUM_CLASSES-1));
  assign cand_s       = score_r[ptr_r];
  assign better_s     = cand_s > best_r;
  assign best_n_s     = better_s ? cand_s : best_r;
  assign idx_n_s      = better_s ? ptr_r : idx_r;

  // Per-class chunk popcounts
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      pc_s[k] = popcount(bus.and_vec[k*BITWIDTH +: BITWIDTH]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_n = ST_ACCUM;
        else           state_n = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_chunk_s) state_n = ST_ARGMAX;
        else              state_n = ST_ACCUM;
      end
      ST_ARGMAX: begin
        if (arg_last_s) state_n = ST_DONE;
        else            state_n = ST_ARGMAX;
      end
      ST_DONE: begin
        if (bus.start) state_n = ST_ACCUM;
        else           state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Score accumulation and chunk counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_r[k] <= {CNT_W{1'b0}};
      chunk_cnt_r <= {CHK_W{1'b0}};
    end else if (clear_s) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_r[k] <= {CNT_W{1'b0}};
      chunk_cnt_r <= {CHK_W{1'b0}};
    end else if (take_s) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_r[k] <= score_r[k] + pc_s[k];
      chunk_cnt_r <= chunk_cnt_r + CHK_W'(1);
    end
  end

  // Sequential argmax scan; ptr stops at the last class so it never indexes past the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r  <= {IDX_W{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
      best_r <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (arg_first_s) begin
      best_r <= score_r[0];
      idx_r  <= {IDX_W{1'b0}};
      ptr_r  <= IDX_W'(1);
    end else if (state_r == ST_ARGMAX) begin
      best_r <= best_n_s;
      idx_r  <= idx_n_s;
      if (!arg_last_s) ptr_r <= ptr_r + IDX_W'(1);
    end
  end

  // Registered outputs; status flags follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_idx_r  <= {IDX_W{1'b0}};
      best_score_r <= {CNT_W{1'b0}};
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      if (arg_last_s) begin
        class_idx_r  <= idx_n_s;
        best_score_r <= best_n_s;
      end
      done_r     <= (state_n == ST_DONE);
      busy_r     <= (state_n == ST_ACCUM) || (state_n == ST_ARGMAX);
      in_ready_r <= (state_n == ST_ACCUM);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.class_idx  = class_idx_r;
  assign bus.best_score = best_score_r;
endmodule

// File: tb/tb_assoc_popcount_argmax.sv
// Randomized self-checking bench for assoc_popcount_argmax against a per-query popcount/argmax model.
module tb_assoc_popcount_argmax;
  localparam int BITWIDTH    = 5;
  localparam int NUM_CLASSES = 26;
  localparam int NUM_CHUNKS  = 4;
  localparam int VW          = NUM_CLASSES*BITWIDTH;

  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst_n;

  assoc_popcount_argmax_if #(
    .BITWIDTH(BITWIDTH), .NUM_CLASSES(NUM_CLASSES), .NUM_CHUNKS(NUM_CHUNKS)
  ) bus ();

  assoc_popcount_argmax #(
    .BITWIDTH(BITWIDTH), .NUM_CLASSES(NUM_CLASSES), .NUM_CHUNKS(NUM_CHUNKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_fail;
  vec_t data_q  [$];
  bit   vld_q   [$];
  vec_t taken_q [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum popcounts of the accepted chunks, first strict maximum wins
  task automatic model(output int eidx, output int escore);
    int   s [NUM_CLASSES];
    vec_t v;
    for (int k = 0; k < NUM_CLASSES; k++) s[k] = 0;
    foreach (taken_q[i]) begin
      v = taken_q[i];
      for (int k = 0; k < NUM_CLASSES; k++) s[k] += $countones(v[k*BITWIDTH +: BITWIDTH]);
    end
    eidx   = 0;
    escore = s[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (s[k] > escore) begin
        escore = s[k];
        eidx   = k;
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*BITWIDTH +: BITWIDTH] = 5'($urandom_range(0, 31));
    return v;
  endfunction

  function automatic vec_t fill(input logic [BITWIDTH-1:0] base);
    vec_t v;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*BITWIDTH +: BITWIDTH] = base;
    return v;
  endfunction

  task automatic begin_query();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    taken_q.delete();
    check("accum_busy", bus.busy, 1);
    check("accum_in_ready", bus.in_ready, 1);
  endtask

  task automatic feed(input int start_at);
    foreach (data_q[i]) begin
      bus.and_vec  = data_q[i];
      bus.in_valid = vld_q[i];
      bus.start    = (i == start_at);
      check("in_ready_accum", bus.in_ready, 1);
      if (vld_q[i]) taken_q.push_back(data_q[i]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    data_q.delete();
    vld_q.delete();
  endtask

  task automatic push_chunk(input vec_t v, input bit vld);
    data_q.push_back(v);
    vld_q.push_back(vld);
  endtask

  task automatic finish_query(input bit junk, input int start_at_cyc, input bit restart);
    int cyc;
    int eidx;
    int escore;
    model(eidx, escore);
    cyc = 1;
    check("argmax_busy", bus.busy, 1);
    check("argmax_in_ready", bus.in_ready, 0);
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.and_vec  = rand_vec();
      end
      bus.start = (cyc == start_at_cyc);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("latency", cyc, NUM_CLASSES + 1);
    check("class_idx", bus.class_idx, eidx);
    check("best_score", bus.best_score, escore);
    check("done_busy", bus.busy, 0);
    if (restart) begin
      begin_query();
    end else begin
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      check("hold_idx", bus.class_idx, eidx);
      check("hold_score", bus.best_score, escore);
    end
  endtask

  task automatic random_query(input int start_at);
    int nv;
    nv = 0;
    while (nv < NUM_CHUNKS) begin
      if ($urandom_range(0, 2) != 0) begin
        push_chunk(rand_vec(), 1'b1);
        nv++;
      end else begin
        push_chunk(rand_vec(), 1'b0);
      end
    end
    feed(start_at);
  endtask

  initial begin
    vec_t v;
    bit   pat [7];
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.and_vec  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_class_idx", bus.class_idx, 0);
    check("rst_best_score", bus.best_score, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.and_vec  = fill(5'b11111);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_ignores_valid", bus.busy, 0);

    // T1: reset in the middle of accumulation
    begin_query();
    push_chunk(fill(5'b11111), 1'b1);
    push_chunk(fill(5'b11111), 1'b1);
    feed(-1);
    rst_n = 1'b0;
    #2;
    check("t1_busy", bus.busy, 0);
    check("t1_in_ready", bus.in_ready, 0);
    check("t1_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_query();
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(rand_vec(), 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);

    // T2: single clear winner
    begin_query();
    v = fill(5'b00001);
    v[7*BITWIDTH +: BITWIDTH] = 5'b11111;
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(v, 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);
    check("t2_idx", bus.class_idx, 7);
    check("t2_score", bus.best_score, 20);

    // T3: tie resolved to the lower index
    begin_query();
    v = fill(5'b00100);
    v[3*BITWIDTH +: BITWIDTH]  = 5'b10101;
    v[20*BITWIDTH +: BITWIDTH] = 5'b00111;
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(v, 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);
    check("t3_idx", bus.class_idx, 3);
    check("t3_score", bus.best_score, 12);

    // T4: stalls, plus chunks offered during the scan
    begin_query();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (pat[i]) push_chunk(rand_vec(), pat[i]);
    feed(-1);
    finish_query(1'b1, -1, 1'b0);

    // T5: start during ACCUM and ARGMAX is ignored; start in DONE restarts
    begin_query();
    push_chunk(rand_vec(), 1'b1);
    push_chunk(rand_vec(), 1'b1);
    push_chunk(rand_vec(), 1'b0);
    push_chunk(rand_vec(), 1'b1);
    push_chunk(rand_vec(), 1'b1);
    feed(2);
    finish_query(1'b0, 5, 1'b1);
    v = fill(5'b00000);
    v[25*BITWIDTH +: BITWIDTH] = 5'b00001;
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(v, 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);
    check("t5_idx", bus.class_idx, 25);
    check("t5_score", bus.best_score, 4);

    // T6: extremes
    begin_query();
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(fill(5'b00000), 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);
    check("t6_zero_idx", bus.class_idx, 0);
    check("t6_zero_score", bus.best_score, 0);
    begin_query();
    for (int i = 0; i < NUM_CHUNKS; i++) push_chunk(fill(5'b11111), 1'b1);
    feed(-1);
    finish_query(1'b0, -1, 1'b0);
    check("t6_ones_idx", bus.class_idx, 0);
    check("t6_ones_score", bus.best_score, 20);

    // Randomized queries with random stalls and occasional scan-time chunks
    for (int q = 0; q < 10; q++) begin
      begin_query();
      random_query((q % 3 == 0) ? 1 : -1);
      finish_query(1'(q % 2), (q % 4 == 1) ? 10 : -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected below 200000", $time);
    $fatal(1);
  end
endmodule
